// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: decode-side controls into the next-PC stage and the
// fetch address / link / status signals coming back out of it.
// Optional feature macro: BRANCH_PERF_CNT_EN (adds taken_cnt).
//
// There is no valid/ready pair on this bus. instr_valid qualifies the
// controls for one cycle, and stall holds that instruction in place.
// An instruction is consumed on a rising edge only when instr_valid=1,
// stall=0 and the unit is not halted. Controls are sampled fresh every
// cycle, so nothing is captured while the instruction waits.
interface next_pc_unit_if #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 26
);
   logic              instr_valid;
   logic              stall;
   logic              JCout;
   logic              UncondJump;
   logic              JumpReg;
   logic              Call;
   logic              halt;
   logic              resume;
   logic [OFF_W-1:0]  offset;
   logic [ADDR_W-1:0] rs_val;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] link_addr;
   logic              link_we;
   logic              branch_taken;
   logic              halted;
   logic              misalign_err;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0]       taken_cnt;
`endif

   // Decoder / fetch side
   modport master (
      output instr_valid, stall, JCout, UncondJump, JumpReg, Call,
             halt, resume, offset, rs_val,
`ifdef BRANCH_PERF_CNT_EN
      input  taken_cnt,
`endif
      input  pc, link_addr, link_we, branch_taken, halted, misalign_err
   );

   // Next-PC unit side
   modport slave (
      input  instr_valid, stall, JCout, UncondJump, JumpReg, Call,
             halt, resume, offset, rs_val,
`ifdef BRANCH_PERF_CNT_EN
      output taken_cnt,
`endif
      output pc, link_addr, link_we, branch_taken, halted, misalign_err
   );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: program counter, next-PC select, RUN/HALT state machine
// and link-register write strobe for the single-cycle core.
// Optional feature macro: BRANCH_PERF_CNT_EN (saturating taken-branch
// counter on bus.taken_cnt).
// The FSM state is visible on bus.halted, which is 1 exactly in HALT.
module next_pc_unit #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 26
) (
   input logic           clk,
   input logic           rst,
   next_pc_unit_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              misalign_q;

   logic              advance;
   logic              accept;
   logic              jump_rel;
   logic [ADDR_W-1:0] off_words;
   logic [ADDR_W-1:0] pc_seq;
   logic [ADDR_W-1:0] pc_rel;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;

   // An instruction is consumed only while running. A consumed halt
   // freezes the PC instead of being treated as a normal step.
   assign advance  = bus.instr_valid & ~bus.stall & (state_q == RUN);
   assign accept   = advance & ~bus.halt;
   assign jump_rel = bus.UncondJump | bus.JCout;

   // Candidate targets. The offset is in words and is sign-extended
   // before scaling. All adds wrap modulo 2^ADDR_W.
   assign off_words = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
   assign pc_seq    = pc_q + ADDR_W'(4);
   assign pc_rel    = pc_seq + (off_words << 2);
   assign pc_reg    = {bus.rs_val[ADDR_W-1:2], 2'b00};

   // Priority select: register jump, then relative jump, then sequential
   always_comb begin
      pc_next = pc_seq;
      if (bus.JumpReg) begin
         pc_next = pc_reg;
      end else if (jump_rel) begin
         pc_next = pc_rel;
      end
   end

   // RUN/HALT state machine together with the PC and the sticky misalign flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= '0;
         misalign_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (advance && bus.halt) begin
                  // PC keeps pointing at the halt instruction
                  state_q <= HALT;
               end else if (accept) begin
                  pc_q <= pc_next;
                  if (bus.JumpReg && (bus.rs_val[1:0] != 2'b00)) begin
                     misalign_q <= 1'b1;
                  end
               end
            end
            HALT: begin
               if (bus.resume) begin
                  state_q <= RUN;
                  pc_q    <= pc_seq;
               end
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   // Output drive. Both strobes are forced low while reset is high.
   assign bus.pc           = pc_q;
   assign bus.link_addr    = pc_seq;
   assign bus.halted       = (state_q == HALT);
   assign bus.misalign_err = misalign_q;
   assign bus.link_we      = ~rst & accept & bus.Call;
   assign bus.branch_taken = ~rst & accept & (bus.JumpReg | jump_rel);

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] taken_cnt_q;

   // Saturating count of cycles with branch_taken high
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt_q <= '0;
      end else if (bus.branch_taken && (taken_cnt_q != 32'hFFFF_FFFF)) begin
         taken_cnt_q <= taken_cnt_q + 32'd1;
      end
   end

   assign bus.taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and random stimulus for next_pc_unit. Each
// driven cycle pushes its expected outputs, taken from a behavioural
// model, into a queue. An independent monitor pops and compares them.
// Optional feature macro: BRANCH_PERF_CNT_EN (also checks taken_cnt).
module tb_next_pc_unit;

   localparam int ADDR_W = 32;
   localparam int OFF_W  = 26;
   // Expected record: {taken_cnt, pc, link_addr, link_we, branch_taken, halted, misalign_err}
   localparam int EW = 32 + 32 + 32 + 4;

   logic clk;
   logic rst;

   next_pc_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

   next_pc_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int checks;
   int errors;

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_mis;
   logic [31:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs, record the expected outputs for this
   // cycle, then advance the model across the next rising edge.
   task automatic step(input logic r, input logic v, input logic st,
                       input logic jc, input logic uj, input logic jr,
                       input logic call, input logic h, input logic res,
                       input logic [OFF_W-1:0] off, input logic [31:0] rs,
                       input bit record);
      bit   consumed;
      bit   taken;
      bit   lw;
      int   words;
      @(negedge clk);
      rst            = r;
      bus.instr_valid = v;
      bus.stall      = st;
      bus.JCout      = jc;
      bus.UncondJump = uj;
      bus.JumpReg    = jr;
      bus.Call       = call;
      bus.halt       = h;
      bus.resume     = res;
      bus.offset     = off;
      bus.rs_val     = rs;

      consumed = v && !st && !m_halted && !h;
      taken    = !r && consumed && (jr || uj || jc);
      lw       = !r && consumed && call;
      if (record) begin
         exp_q.push_back({m_cnt, m_pc, m_pc + 32'd4, lw, taken, m_halted, m_mis});
      end

      // Signed value of the word offset
      words = int'(off);
      if (off >= 26'(1 << 25)) words = words - (1 << 26);

      if (r) begin
         m_pc = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
      end else begin
         if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (m_halted) begin
            if (res) begin
               m_halted = 0;
               m_pc     = m_pc + 4;
            end
         end else if (v && !st && h) begin
            m_halted = 1;
         end else if (consumed) begin
            if (jr) begin
               m_pc = rs - (rs % 4);
               if (rs % 4 != 0) m_mis = 1;
            end else if (uj || jc) begin
               m_pc = m_pc + 4 + words * 4;
            end else begin
               m_pc = m_pc + 4;
            end
         end
      end
   endtask

   // ---------------- driver shorthands ----------------
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
   endtask

   task automatic seq();
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
   endtask

   task automatic goto_pc(input logic [31:0] a);
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, '0, a, 1);
   endtask

   task automatic do_rst();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc",           bus.pc,                   e[67:36]);
         chk("link_addr",    bus.link_addr,            e[35:4]);
         chk("link_we",      32'(bus.link_we),         32'(e[3]));
         chk("branch_taken", 32'(bus.branch_taken),    32'(e[2]));
         chk("halted",       32'(bus.halted),          32'(e[1]));
         chk("misalign_err", 32'(bus.misalign_err),    32'(e[0]));
`ifdef BRANCH_PERF_CNT_EN
         chk("taken_cnt",    bus.taken_cnt,            e[99:68]);
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      m_pc = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
      rst = 1'b1;
      bus.instr_valid = 0; bus.stall = 0; bus.JCout = 0; bus.UncondJump = 0;
      bus.JumpReg = 0; bus.Call = 0; bus.halt = 0; bus.resume = 0;
      bus.offset = '0; bus.rs_val = '0;

      // First reset cycle: DUT state is still unknown, so nothing is recorded
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 0);
      do_rst();

      // Three sequential instructions: 0, 4, 8, then 12
      seq(); seq(); seq(); idle();

      // Conditional branch backwards from 0x100 by -2 words gives 0xFC
      goto_pc(32'h100);
      step(0, 1, 0, 1, 0, 0, 0, 0, 0, 26'h3FFFFFE, '0, 1);
      idle();

      // Call with relative jump from 0x40: link 0x44, target 0x84
      goto_pc(32'h40);
      step(0, 1, 0, 0, 1, 0, 1, 0, 0, 26'h10, '0, 1);
      idle();

      // JumpReg beats JCout; misaligned target sets the sticky flag
      goto_pc(32'h20);
      step(0, 1, 0, 1, 0, 1, 0, 0, 0, 26'h5, 32'h203, 1);
      idle(); seq(); seq();

      // Stall for four cycles with a pending jump, then let it go
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 0, 1, 0, 0, 26'h8, '0, 1);
      step(0, 1, 0, 0, 1, 0, 1, 0, 0, 26'h8, '0, 1);
      idle();

      // Halt at 0x80, hold ten cycles under noisy inputs, then resume
      goto_pc(32'h80);
      step(0, 1, 0, 0, 0, 0, 0, 1, 0, '0, '0, 1);
      for (int i = 0; i < 10; i++)
         step(0, 1, 0, 1, 1, 1, 1, 1, 0, 26'h3, 32'h1234, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, '0, 1);
      idle();

      // Halt together with resume while running: halt wins
      step(0, 1, 0, 0, 0, 0, 0, 1, 1, '0, '0, 1);
      idle(); idle();
      // Reset while halted returns to RUN at 0 and clears misalign_err
      do_rst();
      idle(); seq(); idle();

      // Resume while running is ignored
      step(0, 1, 0, 0, 0, 0, 0, 0, 1, '0, '0, 1);
      idle();

      // Reset overrides a pending jump on the same edge
      step(1, 1, 0, 0, 1, 0, 1, 0, 0, 26'h40, '0, 1);
      idle();

      // PC wraps past the top of the address space
      goto_pc(32'hFFFF_FFFC);
      seq(); idle();
      goto_pc(32'h0000_0010);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0, 26'h2000000, '0, 1);
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rs;
         logic [OFF_W-1:0] off;
         rs  = $urandom;
         off = OFF_W'($urandom);
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0,
              off, rs, 1);
      end
      idle();

      // Drain: every recorded cycle must have been compared
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
